// File: rtl/bmi_calculator.sv
// ============================================================================
// Module   : bmi_calculator
// Purpose  : Multi-cycle BMI front end. It computes height^2 with a shift-add
//            multiplier, then weight*SCALE/height^2 with a restoring divider.
//            The result is held on an 8-bit saturated category output.
// Option   : BMI_ROUND_EN selects round-half-up instead of floor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bmi_calculator #(
    parameter int SCALE = 10000,
    parameter int NUM_W = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] weight_i,
    input  logic [7:0] height_i,
    output logic       busy_o,
    output logic       valid_o,
    output logic       err_o,
    output logic [7:0] category_o
);

    localparam int                 CNT_W    = $clog2(NUM_W);
    localparam logic [CNT_W-1:0]   SQ_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0]   DIV_LAST = CNT_W'(NUM_W - 1);
    localparam logic [NUM_W-1:0]   SCALE_W  = NUM_W'(SCALE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SQUARE = 2'd1,
        S_DIVIDE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q;
    logic [7:0]       weight_q;
    logic [7:0]       height_q;
    logic [15:0]      prod_q;
    logic [16:0]      rem_q;
    logic [NUM_W-2:0] quo_q;
    logic [CNT_W-1:0] cnt_q;

    logic [8:0]       sq_top_d;
    logic [NUM_W-1:0] num_w;
    logic             num_bit;
    logic [17:0]      trial;
    logic [17:0]      diff;
    logic             ge;
    logic [16:0]      rem_d;
    logic [NUM_W-1:0] quo_d;
    logic [NUM_W-1:0] quo_fin;
    logic [7:0]       category_d;

    always_comb begin
        // Multiplier occupies prod_q[7:0] and is consumed LSB first while the
        // partial product grows in from the top.
        sq_top_d = {1'b0, prod_q[15:8]} + (prod_q[0] ? {1'b0, height_q} : 9'd0);

        num_w   = {{(NUM_W-8){1'b0}}, weight_q} * SCALE_W;
        num_bit = num_w[DIV_LAST - cnt_q];
        trial   = {rem_q, num_bit};
        diff    = trial - {2'b00, prod_q};
        // The trial value never exceeds 17 bits, so bit 17 is the borrow.
        ge      = ~diff[17];
        rem_d   = ge ? diff[16:0] : trial[16:0];
        quo_d   = {quo_q, ge};

`ifdef BMI_ROUND_EN
        quo_fin = quo_d + NUM_W'({rem_d, 1'b0} >= {2'b00, prod_q});
`else
        quo_fin = quo_d;
`endif
        category_d = (|quo_fin[NUM_W-1:8]) ? 8'hFF : quo_fin[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            weight_q   <= 8'd0;
            height_q   <= 8'd0;
            prod_q     <= 16'd0;
            rem_q      <= 17'd0;
            quo_q      <= '0;
            cnt_q      <= '0;
            busy_o     <= 1'b0;
            valid_o    <= 1'b0;
            err_o      <= 1'b0;
            category_o <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        weight_q <= weight_i;
                        height_q <= height_i;
                        busy_o   <= 1'b1;
                        cnt_q    <= '0;
                        if (height_i == 8'd0) begin
                            err_o      <= 1'b1;
                            category_o <= 8'hFF;
                            valid_o    <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            err_o   <= 1'b0;
                            prod_q  <= {8'd0, height_i};
                            rem_q   <= 17'd0;
                            quo_q   <= '0;
                            state_q <= S_SQUARE;
                        end
                    end
                end
                S_SQUARE: begin
                    prod_q <= {sq_top_d, prod_q[7:1]};
                    if (cnt_q == SQ_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_DIVIDE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d[NUM_W-2:0];
                    if (cnt_q == DIV_LAST) begin
                        cnt_q      <= '0;
                        category_o <= category_d;
                        valid_o    <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
